mastermind_scorer: RTL
======================

# mastermind_scorer

Parametrised, clocked Mastermind scoring engine with game tracking. It scores a guess against a secret code of PEGS pegs, each peg COLOR_W bits, using exact per-colour multiset matching. It tracks the turn count and win/lose state up to MAX_TURNS guesses. It sits between the guess-entry/seven-segment logic and the LEDR peg display, and replaces the fixed four-peg, button-edge-triggered scoring.

## Interface
Parameters:
- PEGS, 4, pegs per code (≥1)
- COLOR_W, 3, bits per peg; all 2^COLOR_W values are legal colours (no reserved sentinel)
- MAX_TURNS, 10, guesses allowed per game (≥1)

Ports (CW = $clog2(PEGS+1), TW = $clog2(MAX_TURNS+1)):
- MAX10_CLK1_50  in  1  system clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request to score guess against secret; sampled only in IDLE
- new_game  in  1  clear game state; aborts a scoring in progress
- guess  in  PEGS*COLOR_W  peg k at [k*COLOR_W +: COLOR_W]
- secret  in  PEGS*COLOR_W  same packing as guess
- busy  out  1  high in SCAN and MATCH
- done  out  1  one-cycle pulse when a result is published
- black  out  CW  pegs correct in colour and position
- white  out  CW  pegs correct in colour, wrong position
- peg_led  out  2*PEGS  [PEGS-1:0] = black thermometer; [2*PEGS-1:PEGS] = white thermometer
- win  out  1  sticky; the last scored guess had black == PEGS
- lose  out  1  sticky; MAX_TURNS guesses were scored without a win
- turn  out  TW  guesses scored this game; saturates at MAX_TURNS

## Operation
- States: IDLE, SCAN, MATCH, DONE.
- IDLE → SCAN on start=1 && !new_game && !win && !lose.
  - guess and secret are captured into internal registers, so the inputs may change afterwards.
  - Clear: black accumulator, 2^COLOR_W-entry guess and secret histograms (CW bits each), white accumulator, and index counters.
- SCAN: one peg per cycle, p = 0..PEGS-1.
  - If g[p]==s[p], increment black_acc.
  - Otherwise increment hist_g[g[p]] and hist_s[s[p]].
  - After p=PEGS-1 → MATCH.
- MATCH: one colour per cycle, c = 0..2^COLOR_W-1.
  - white_acc += min(hist_g[c], hist_s[c]).
  - After the last colour → DONE.
- DONE: stays one cycle, then → IDLE. Registered on entry:
  - done=1; black=black_acc; white=white_acc; peg_led updated from black/white.
  - turn = turn+1, saturating.
  - win=1 if black_acc==PEGS.
  - lose=1 if the new turn==MAX_TURNS and win is not set. A winning guess on the final turn gives win=1, lose=0.
- start is ignored outside IDLE (no queueing) and while win or lose is set.
- new_game in IDLE: next edge clears turn, win, lose, black, white, peg_led.
- new_game in SCAN/MATCH/DONE: same clear, return to IDLE; no done pulse, no turn increment.
- new_game and start in the same cycle: new_game wins; start is dropped.
- Accumulators never overflow: black+white ≤ PEGS, which fits in CW bits.

## Timing
- rst asserted, at any time including mid-scan: immediately state=IDLE and all outputs 0 (busy, done, black, white, peg_led, win, lose, turn); histograms cleared.
- Edge E0 accepts start. busy=1 from after E0 through the end of MATCH.
- done=1 for exactly the cycle after edge E0+PEGS+2^COLOR_W; busy=0 in that cycle. Latency is PEGS+2^COLOR_W+1 cycles (13 at defaults).
- black, white, peg_led, turn, win and lose change only at that edge, at new_game or at rst. They hold between results.
- Earliest next accepted start: the cycle after done.

## Test plan
- Defaults, secret pegs0..3 = 2,1,1,1, guess 2,1,1,1, start at E0:
  - done exactly 13 cycles later; black=4, white=0, peg_led=8'h0F; win=1, turn=1.
  - A further start produces no busy.
- Duplicates: secret 2,1,1,1, guess 1,2,2,2:
  - black=0, white=2, peg_led=8'h30, win=0.
- Mixed: secret 0,1,2,3, guess 0,2,1,7:
  - black=1, white=2, peg_led=8'h31.
- Lose path: 10 non-winning guesses → lose=1 with the 10th done, turn=10. An 11th start is ignored. new_game clears lose and turn to 0.
- Abort:
  - new_game asserted 3 cycles after start: busy drops next cycle, no done, turn unchanged.
  - rst mid-MATCH: all outputs 0 immediately; a subsequent start scores normally.
- Parameter sweep PEGS=6, COLOR_W=2, MAX_TURNS=3:
  - secret 0,0,1,1,2,3, guess 0,1,0,1,3,3 → done at 11 cycles, black=3, white=2, peg_led=12'h0C7.
  - 3 misses set lose.

Source files
------------

// File: rtl/mastermind_scorer.sv
// Mastermind scoring engine with game tracking.
// A guess is scored against the secret in two passes. The first pass walks the
// pegs: it counts exact hits and builds colour histograms of the leftover pegs.
// The second pass walks the colours and sums min(hist_g, hist_s) to get whites.
// The engine also tracks the turn count and the sticky win/lose flags.
module mastermind_scorer #(
  parameter int PEGS      = 4,
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 10
) (
  input  logic                               MAX10_CLK1_50,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               new_game,
  input  logic [PEGS*COLOR_W-1:0]            guess,
  input  logic [PEGS*COLOR_W-1:0]            secret,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(PEGS+1)-1:0]          black,
  output logic [$clog2(PEGS+1)-1:0]          white,
  output logic [2*PEGS-1:0]                  peg_led,
  output logic                               win,
  output logic                               lose,
  output logic [$clog2(MAX_TURNS+1)-1:0]     turn
);

  localparam int CW   = $clog2(PEGS + 1);
  localparam int TW   = $clog2(MAX_TURNS + 1);
  localparam int NCOL = 2 ** COLOR_W;
  localparam int PW   = (PEGS > 1) ? $clog2(PEGS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, MATCH, DONE} state_t;

  state_t state_q, state_d;

  logic [COLOR_W-1:0] g_q [PEGS];
  logic [COLOR_W-1:0] s_q [PEGS];
  logic [CW-1:0]      hist_g [NCOL];
  logic [CW-1:0]      hist_s [NCOL];
  logic [CW-1:0]      black_acc;
  logic [CW-1:0]      white_acc;
  logic [PW-1:0]      peg_idx;
  logic [COLOR_W-1:0] col_idx;

  logic               accept;
  logic               last_peg;
  logic               last_col;
  logic [CW-1:0]      col_min;
  logic [CW-1:0]      white_sum;
  logic [TW-1:0]      turn_inc;

  // Builds a thermometer code with the lowest n bits set.
  function automatic logic [PEGS-1:0] thermo(input logic [CW-1:0] n);
    logic [PEGS-1:0] t;
    for (int i = 0; i < PEGS; i++) begin
      t[i] = (CW'(i) < n);
    end
    return t;
  endfunction

  // Computes the next state, the busy flag and the per-cycle scoring terms.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    busy      = 1'b0;
    accept    = (state_q == IDLE) && start && !new_game && !win && !lose;
    last_peg  = (peg_idx == PW'(PEGS - 1));
    last_col  = (col_idx == '1);
    col_min   = (hist_g[col_idx] < hist_s[col_idx]) ? hist_g[col_idx] : hist_s[col_idx];
    white_sum = white_acc + col_min;
    turn_inc  = (turn == TW'(MAX_TURNS)) ? turn : turn + TW'(1);

    case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (last_peg) state_d = MATCH;
      end
      MATCH: begin
        busy = 1'b1;
        if (last_col) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A game clear always wins over any transition, including a start.
    if (new_game) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand capture, peg scan, colour match and result publishing.
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      // NOTE: the histograms are small flop arrays rather than a RAM, so they
      // can be cleared by the async reset; a RAM macro could not.
      for (int c = 0; c < NCOL; c++) begin
        hist_g[c] <= '0;
        hist_s[c] <= '0;
      end
      for (int k = 0; k < PEGS; k++) begin
        g_q[k] <= '0;
        s_q[k] <= '0;
      end
      black_acc <= '0;
      white_acc <= '0;
      peg_idx   <= '0;
      col_idx   <= '0;
      done      <= 1'b0;
      black     <= '0;
      white     <= '0;
      peg_led   <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      turn      <= '0;
    end else begin
      done <= 1'b0;
      if (new_game) begin
        turn    <= '0;
        win     <= 1'b0;
        lose    <= 1'b0;
        black   <= '0;
        white   <= '0;
        peg_led <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              for (int k = 0; k < PEGS; k++) begin
                g_q[k] <= guess[k*COLOR_W +: COLOR_W];
                s_q[k] <= secret[k*COLOR_W +: COLOR_W];
              end
              for (int c = 0; c < NCOL; c++) begin
                hist_g[c] <= '0;
                hist_s[c] <= '0;
              end
              black_acc <= '0;
              white_acc <= '0;
              peg_idx   <= '0;
              col_idx   <= '0;
            end
          end
          SCAN: begin
            if (g_q[peg_idx] == s_q[peg_idx]) begin
              black_acc <= black_acc + CW'(1);
            end else begin
              hist_g[g_q[peg_idx]] <= hist_g[g_q[peg_idx]] + CW'(1);
              hist_s[s_q[peg_idx]] <= hist_s[s_q[peg_idx]] + CW'(1);
            end
            peg_idx <= peg_idx + PW'(1);
          end
          MATCH: begin
            white_acc <= white_sum;
            col_idx   <= col_idx + COLOR_W'(1);
            if (last_col) begin
              done    <= 1'b1;
              black   <= black_acc;
              white   <= white_sum;
              peg_led <= {thermo(white_sum), thermo(black_acc)};
              turn    <= turn_inc;
              win     <= (black_acc == CW'(PEGS));
              lose    <= (turn_inc == TW'(MAX_TURNS)) && (black_acc != CW'(PEGS));
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
